// File: rtl/sd_host_pkg.sv
// Shared SD host types and constants: FSM state encoding, default frame width, CRC7 polynomial.
package sd_host_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } p2s_state_t;

    localparam int         P2S_DEFAULT_WIDTH = 48;
    localparam logic [6:0] CRC7_POLY         = 7'h09;

    // One serial CRC7 step: x^7 + x^3 + 1, MSB-first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic w_fb;
        w_fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator; result updates one cycle after each enabled bit, no backpressure.
// i_clr restarts from zero; with i_en also high, the clear and the first bit land in the same edge.
module sd_crc7
    import sd_host_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_din,
    output logic [6:0] o_crc
);

    logic [6:0] r_crc;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_crc <= 7'h00;
        end else if (i_en) begin
            r_crc <= crc7_step(i_clr ? 7'h00 : r_crc, i_din);
        end else if (i_clr) begin
            r_crc <= 7'h00;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sd_parallel_to_serial.sv
// SD CMD-path frame serializer: WIDTH bits MSB-first, finished at edge WIDTH; no backpressure once started.
// Optional macro P2S_CRC7_EN replaces transmitted bits 7..1 with the CRC7 of bits WIDTH-1..8.
module sd_parallel_to_serial
    import sd_host_pkg::*;
#(
    parameter int WIDTH = P2S_DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start_sending,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             finished,
    output logic             serial_out
);

    localparam int CW = $clog2(WIDTH);

    p2s_state_t       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_serial;
    logic             r_finished;

    // Counter holds how many bits remain after the one on the line; w_pos is the next bit index.
    logic [CW-1:0]    w_pos;
    logic             w_next_bit;

    assign w_pos = r_cnt - CW'(1);

`ifdef P2S_CRC7_EN
    logic [6:0] w_crc;
    logic       w_crc_clr;
    logic       w_crc_en;
    logic       w_crc_din;

    assign w_crc_clr = (r_state == IDLE) && start_sending;
    assign w_crc_en  = w_crc_clr ||
                       ((r_state == SHIFT) && (r_cnt != '0) && (w_pos >= CW'(8)));
    assign w_crc_din = w_crc_clr ? parallel_in[WIDTH-1] : r_shift[w_pos];

    sd_crc7 u_crc7 (
        .CLK   (CLK),
        .RESET (RESET),
        .i_clr (w_crc_clr),
        .i_en  (w_crc_en),
        .i_din (w_crc_din),
        .o_crc (w_crc)
    );
`endif

    always_comb begin
        w_next_bit = r_shift[w_pos];
`ifdef P2S_CRC7_EN
        // Positions 7..1 carry the frozen CRC, MSB at position 7.
        if ((w_pos <= CW'(7)) && (w_pos != '0)) begin
            w_next_bit = w_crc[w_pos[2:0] - 3'd1];
        end
`endif
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_serial   <= 1'b1;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_serial   <= 1'b1;
                    r_finished <= 1'b0;
                    if (start_sending) begin
                        r_shift  <= parallel_in;
                        r_serial <= parallel_in[WIDTH-1];
                        r_cnt    <= CW'(WIDTH - 1);
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_cnt == '0) begin
                        r_serial   <= 1'b1;
                        r_finished <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_serial <= w_next_bit;
                        r_cnt    <= w_pos;
                    end
                end
                DONE: begin
                    if (!start_sending) begin
                        r_finished <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_serial   <= 1'b1;
                    r_finished <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign serial_out = r_serial;
    assign finished   = r_finished;

endmodule

// File: tb/tb_sd_parallel_to_serial.sv
// Bench for sd_parallel_to_serial: directed sequence plus random frames against a frame-level model.
module tb_sd_parallel_to_serial;

    localparam int W = 48;

    logic         CLK;
    logic         RESET;
    logic         start_sending;
    logic [W-1:0] parallel_in;
    logic         finished;
    logic         serial_out;

    int n_assert = 0;
    int n_fail   = 0;

    sd_parallel_to_serial #(.WIDTH(W)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .start_sending (start_sending),
        .parallel_in   (parallel_in),
        .finished      (finished),
        .serial_out    (serial_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: the word as it appears on the wire, computed by polynomial long division.
    function automatic logic [W-1:0] model_tx(input logic [W-1:0] f);
        logic [W-1:0] tx;
        tx = f;
`ifdef P2S_CRC7_EN
        begin
            logic [70:0] r;
            r = 71'(f >> 8) << 7;
            for (int i = W - 2; i >= 7; i--) begin
                if (r[i]) r = r ^ (71'h89 << (i - 7));
            end
            tx[7:1] = r[6:0];
        end
`endif
        return tx;
    endfunction

    function automatic logic [W-1:0] rand_frame();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[W-1:0];
    endfunction

    // Sends one frame starting at the next edge; checks every bit slot and the edge-W completion.
    task automatic run_frame(input logic [W-1:0] f, input bit scramble, input int drop_at,
                             output logic [W-1:0] rx);
        logic [W-1:0] tx;
        tx = model_tx(f);
        rx = '0;
        parallel_in   = f;
        start_sending = 1'b1;
        tick();
        for (int k = 0; k < W; k++) begin
            if (scramble && k == 1) parallel_in = '1;
            if (k == drop_at) start_sending = 1'b0;
            check("bit", 64'(serial_out), 64'(tx[W-1-k]));
            check("fin_low_in_frame", 64'(finished), 64'd0);
            rx[W-1-k] = serial_out;
            tick();
        end
        check("fin_at_edge_W", 64'(finished), 64'd1);
        check("idle_high_at_edge_W", 64'(serial_out), 64'd1);
        check("frame_word", 64'(rx), 64'(tx));
    endtask

    initial begin
        logic [W-1:0] rx;
        logic [7:0]   exp_last;

        RESET         = 1'b0;
        start_sending = 1'b1;
        parallel_in   = 48'h19FA_FADB_DBF3;

        for (int i = 0; i < 4; i++) begin
            tick();
            check("reset_serial", 64'(serial_out), 64'd1);
            check("reset_fin", 64'(finished), 64'd0);
        end
        RESET = 1'b1;

        // Known frame, start held through completion.
        run_frame(48'h19FA_FADB_DBF3, 1'b0, -1, rx);
        check("known_first_byte", 64'(rx[W-1:W-8]), 64'h19);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_fin", 64'(finished), 64'd1);
            check("hold_no_retx", 64'(serial_out), 64'd1);
        end
        start_sending = 1'b0;
        tick();
        check("release_fin", 64'(finished), 64'd0);
        check("release_serial", 64'(serial_out), 64'd1);

        // New frame with parallel_in overwritten after the latch edge.
        run_frame(rand_frame(), 1'b1, -1, rx);
        start_sending = 1'b0;
        tick();
        check("fin_clear2", 64'(finished), 64'd0);

        // start_sending dropped mid-frame: frame completes, finished lasts one cycle.
        run_frame(rand_frame(), 1'b0, 3, rx);
        tick();
        check("one_cycle_fin", 64'(finished), 64'd0);
        check("one_cycle_serial", 64'(serial_out), 64'd1);

        // Random frames, each separated by one IDLE edge.
        for (int n = 0; n < 4; n++) begin
            run_frame(rand_frame(), 1'b0, -1, rx);
            start_sending = 1'b0;
            tick();
            check("rand_fin_clear", 64'(finished), 64'd0);
        end

        // CMD0: last byte is CRC7 plus end bit when CRC is enabled.
`ifdef P2S_CRC7_EN
        exp_last = 8'h95;
`else
        exp_last = 8'h01;
`endif
        run_frame(48'h40_0000_0000_01, 1'b0, -1, rx);
        check("cmd0_last_byte", 64'(rx[7:0]), 64'(exp_last));
        start_sending = 1'b0;
        tick();

        // Abort at bit 20 with an asynchronous reset between edges.
        parallel_in   = 48'h0;
        start_sending = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) tick();
        check("abort_prereset_bit", 64'(serial_out), 64'd0);
        #2;
        RESET = 1'b0;
        #1;
        check("abort_serial", 64'(serial_out), 64'd1);
        check("abort_fin", 64'(finished), 64'd0);
        start_sending = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        for (int k = 0; k < W + 4; k++) begin
            tick();
            check("abort_no_fin", 64'(finished), 64'd0);
            check("abort_idle", 64'(serial_out), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
